gvp_stream_packer: RTL and testbench



---
 rtl/gvp_pkg.sv | 27 ++
 rtl/gvp_stream_fifo.sv | 90 +++++++++
 rtl/gvp_stream_packer.sv | 210 +++++++++++++++++++++
 tb/tb_gvp_stream_packer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/gvp_pkg.sv
// rtl/gvp_pkg.sv - shared constants for the GVP stream packer
// Purpose: packet markers, store_data trigger codes and packer FSM state encoding.
package gvp_pkg;

    // Header word0 upper half and end-of-run word (low 16 b carry the overrun count).
    localparam logic [15:0] HDR_MARKER = 16'hFEED;
    localparam logic [31:0] END_MARKER = 32'hE0F0_0000;

    // store_data trigger codes; 3 is treated like SD_NONE.
    localparam logic [1:0] SD_NONE = 2'd0;
    localparam logic [1:0] SD_DATA = 2'd1;
    localparam logic [1:0] SD_HDR  = 2'd2;

    // Packer FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_SRC  = 2'd2;
    localparam logic [1:0] ST_ENDW = 2'd3;

    // Index of the final header word (section-count word).
    localparam logic [1:0] HDR_LAST_IDX = 2'd3;

    function automatic logic [31:0] end_word(input logic [15:0] ovr);
        return END_MARKER | {16'h0000, ovr};
    endfunction

endpackage

// File: rtl/gvp_stream_fifo.sv
// rtl/gvp_stream_fifo.sv - first-word-fall-through FIFO with registered output word
// Purpose: buffers {tlast, tdata} words between the packer FSM and the AXIS output.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   wr_en_i         write request (ignored while full_o)
//   wr_data_i       word to write
//   full_o          storage holds 2**AW words
//   rd_data_o       registered head word (valid while !empty_o)
//   empty_o         no word presented on rd_data_o
//   rd_ready_i      consumer accepts rd_data_o this cycle
//   level_o         words held in storage (wptr - rptr), excludes the output register
module gvp_stream_fifo #(
    parameter int DW = 33,
    parameter int AW = 9
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          full_o,
    output logic [DW-1:0] rd_data_o,
    output logic          empty_o,
    input  logic          rd_ready_i,
    output logic [AW:0]   level_o
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [DW-1:0] out_q, out_d;
    logic          out_vld_q, out_vld_d;

    logic [AW:0]   level;
    logic          mem_empty;
    logic          wr_fire;
    logic          load;

    assign level     = wptr_q - rptr_q;
    assign mem_empty = (wptr_q == rptr_q);
    assign wr_fire   = wr_en_i && (level != FULL_LVL);
    // Refill the output register whenever it is free or being drained this cycle.
    assign load      = !mem_empty && (!out_vld_q || rd_ready_i);

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        if (wr_fire) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (load) begin
            rptr_d    = rptr_q + PTR_ONE;
            out_d     = mem_q[rptr_q[AW-1:0]];
            out_vld_d = 1'b1;
        end else if (rd_ready_i) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign full_o    = (level == FULL_LVL);
    assign rd_data_o = out_q;
    assign empty_o   = !out_vld_q;
    assign level_o   = level;

endmodule

// File: rtl/gvp_stream_packer.sv
// rtl/gvp_stream_packer.sv - packs GVP store_data snapshots into a framed 32-bit AXIS stream
// Purpose: on a store_data trigger, snapshots the sources and gvp section/options, then writes
//   an optional 4-word header and one word per enabled channel into a FIFO feeding M_AXIS.
//   A rising gvp_finished queues an end-of-run word carrying the overrun count.
// Ports:
//   a_clk, a_resetn        clock, asynchronous active-low reset
//   store_data [1:0]       2 = header+data, 1 = data only, 0/3 = none
//   section, options       gvp section count / options, copied into the header
//   gvp_finished           run-finished level; its rising edge requests the end word
//   srcs                   NUM_SRC x 32-bit samples, channel k at [32k+31:32k]
//   src_mask               enabled channels
//   M_AXIS_*               output stream, tlast on the final word of each packet
//   overrun_count          triggers dropped because a packet was still being built
//   fifo_level             words held in the FIFO storage
module gvp_stream_packer
    import gvp_pkg::*;
#(
    parameter int NUM_SRC = 16,
    parameter int FIFO_AW = 9
) (
    input  logic                   a_clk,
    input  logic                   a_resetn,
    input  logic [1:0]             store_data,
    input  logic [31:0]            section,
    input  logic [31:0]            options,
    input  logic                   gvp_finished,
    input  logic [NUM_SRC*32-1:0]  srcs,
    input  logic [NUM_SRC-1:0]     src_mask,
    output logic [31:0]            M_AXIS_tdata,
    output logic                   M_AXIS_tvalid,
    input  logic                   M_AXIS_tready,
    output logic                   M_AXIS_tlast,
    output logic [15:0]            overrun_count,
    output logic [FIFO_AW:0]       fifo_level
);

    localparam int                 IW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [NUM_SRC-1:0] MASK_ONE = NUM_SRC'(1);

    logic [1:0]         state_q, state_d;
    logic [1:0]         hdr_idx_q, hdr_idx_d;
    logic [NUM_SRC-1:0] rem_mask_q, rem_mask_d;
    logic [NUM_SRC-1:0] cap_mask_q;
    logic [31:0]        section_q, options_q;
    logic [31:0]        sample_cnt_q, sample_cnt_d;
    logic [15:0]        overrun_q, overrun_d;
    logic               fin_q;
    logic               end_pend_q, end_pend_d;
    logic [31:0]        src_q [NUM_SRC];

    logic               trig;
    logic               accept;
    logic               fin_rise;
    logic [IW-1:0]      cur_idx;
    logic [NUM_SRC-1:0] rem_next;
    logic [15:0]        mask16;
    logic               wr_en;
    logic [32:0]        wr_word;
    logic               fifo_full;
    logic               fifo_empty;
    logic [32:0]        rd_word;

    // A data-only trigger with no enabled channel would produce an empty packet; ignore it.
    assign trig     = (store_data == SD_HDR) ||
                      ((store_data == SD_DATA) && (src_mask != '0));
    assign accept   = trig && (state_q == ST_IDLE);
    assign fin_rise = gvp_finished && !fin_q;

    // Lowest enabled channel still to be sent; rem_next drops it from the set.
    always_comb begin
        cur_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rem_mask_q[k]) begin
                cur_idx = IW'(k);
            end
        end
    end
    assign rem_next = rem_mask_q & (rem_mask_q - MASK_ONE);

    always_comb begin
        mask16                = '0;
        mask16[NUM_SRC-1:0]   = cap_mask_q;
    end

    always_comb begin
        overrun_d = overrun_q;
        if (trig && (state_q != ST_IDLE) && (overrun_q != 16'hFFFF)) begin
            overrun_d = overrun_q + 16'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        hdr_idx_d    = hdr_idx_q;
        rem_mask_d   = rem_mask_q;
        sample_cnt_d = sample_cnt_q;
        end_pend_d   = end_pend_q || fin_rise;
        wr_en        = 1'b0;
        wr_word      = '0;
        case (state_q)
            ST_IDLE: begin
                // A trigger wins over a pending end word so the END lands after the packet.
                if (accept) begin
                    state_d    = (store_data == SD_HDR) ? ST_HDR : ST_SRC;
                    hdr_idx_d  = '0;
                    rem_mask_d = src_mask;
                end else if (end_pend_q) begin
                    state_d = ST_ENDW;
                end
            end
            ST_HDR: begin
                if (!fifo_full) begin
                    wr_en = 1'b1;
                    case (hdr_idx_q)
                        2'd0:    wr_word = {1'b0, HDR_MARKER, mask16};
                        2'd1:    wr_word = {1'b0, section_q};
                        2'd2:    wr_word = {1'b0, options_q};
                        default: wr_word = {1'b0, sample_cnt_q};
                    endcase
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == HDR_LAST_IDX) begin
                        // With no channels enabled the header closes its own packet.
                        if (cap_mask_q == '0) begin
                            wr_word[32] = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            state_d = ST_SRC;
                        end
                    end
                end
            end
            ST_SRC: begin
                if (!fifo_full) begin
                    wr_en      = 1'b1;
                    wr_word    = {1'b0, src_q[cur_idx]};
                    rem_mask_d = rem_next;
                    if (rem_next == '0) begin
                        wr_word[32]  = 1'b1;
                        sample_cnt_d = sample_cnt_q + 32'd1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: begin
                if (!fifo_full) begin
                    wr_en      = 1'b1;
                    wr_word    = {1'b1, end_word(overrun_q)};
                    end_pend_d = fin_rise;
                    state_d    = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q      <= ST_IDLE;
            hdr_idx_q    <= '0;
            rem_mask_q   <= '0;
            cap_mask_q   <= '0;
            section_q    <= '0;
            options_q    <= '0;
            sample_cnt_q <= '0;
            overrun_q    <= '0;
            fin_q        <= 1'b0;
            end_pend_q   <= 1'b0;
            for (int k = 0; k < NUM_SRC; k++) begin
                src_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            rem_mask_q   <= rem_mask_d;
            sample_cnt_q <= sample_cnt_d;
            overrun_q    <= overrun_d;
            fin_q        <= gvp_finished;
            end_pend_q   <= end_pend_d;
            // The snapshot only moves on an accepted trigger, so dropped ones leave it intact.
            if (accept) begin
                cap_mask_q <= src_mask;
                section_q  <= section;
                options_q  <= options;
                for (int k = 0; k < NUM_SRC; k++) begin
                    src_q[k] <= srcs[32*k +: 32];
                end
            end
        end
    end

    gvp_stream_fifo #(
        .DW (33),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk_i      (a_clk),
        .rst_ni     (a_resetn),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_word),
        .full_o     (fifo_full),
        .rd_data_o  (rd_word),
        .empty_o    (fifo_empty),
        .rd_ready_i (M_AXIS_tready),
        .level_o    (fifo_level)
    );

    assign M_AXIS_tdata  = rd_word[31:0];
    assign M_AXIS_tlast  = rd_word[32];
    assign M_AXIS_tvalid = !fifo_empty;
    assign overrun_count = overrun_q;

endmodule

// File: tb/tb_gvp_stream_packer.sv
// tb/tb_gvp_stream_packer.sv - directed self-checking bench for gvp_stream_packer
module tb_gvp_stream_packer;

    localparam int          NUM_SRC = 16;
    localparam int          FIFO_AW = 4;
    localparam logic [32:0] L       = 33'h1_0000_0000;

    logic                  a_clk = 1'b0;
    logic                  a_resetn = 1'b0;
    logic [1:0]            store_data = 2'd0;
    logic [31:0]           section = '0;
    logic [31:0]           options = '0;
    logic                  gvp_finished = 1'b0;
    logic [NUM_SRC*32-1:0] srcs = '0;
    logic [NUM_SRC-1:0]    src_mask = '0;
    logic [31:0]           M_AXIS_tdata;
    logic                  M_AXIS_tvalid;
    logic                  M_AXIS_tready = 1'b1;
    logic                  M_AXIS_tlast;
    logic [15:0]           overrun_count;
    logic [FIFO_AW:0]      fifo_level;

    gvp_stream_packer #(
        .NUM_SRC (NUM_SRC),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .a_clk         (a_clk),
        .a_resetn      (a_resetn),
        .store_data    (store_data),
        .section       (section),
        .options       (options),
        .gvp_finished  (gvp_finished),
        .srcs          (srcs),
        .src_mask      (src_mask),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tready (M_AXIS_tready),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .overrun_count (overrun_count),
        .fifo_level    (fifo_level)
    );

    always #5 a_clk = ~a_clk;

    int cyc = 0;
    always @(posedge a_clk) cyc <= cyc + 1;

    logic [32:0] got_q [$];
    int          got_cyc [$];
    logic [32:0] exp_q [$];

    // Transfers are recorded mid-cycle; inputs only change just after posedge.
    always @(negedge a_clk) begin
        if (M_AXIS_tvalid && M_AXIS_tready) begin
            got_q.push_back({M_AXIS_tlast, M_AXIS_tdata});
            got_cyc.push_back(cyc);
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    int trig_cyc = 0;

    typedef struct {
        logic [1:0]  sd;
        logic [15:0] mask;
        logic [31:0] sec;
        logic [31:0] opt;
        int          n;
        logic [32:0] w [6];
    } vec_t;

    vec_t vt [7];

    function automatic vec_t mk(input logic [1:0] sd, input logic [15:0] m,
                                input logic [31:0] s, input logic [31:0] o, input int n,
                                input logic [32:0] w0, input logic [32:0] w1,
                                input logic [32:0] w2, input logic [32:0] w3,
                                input logic [32:0] w4, input logic [32:0] w5);
        vec_t v;
        v.sd = sd; v.mask = m; v.sec = s; v.opt = o; v.n = n;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4; v.w[5] = w5;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_srcs(input logic [31:0] base);
        for (int k = 0; k < NUM_SRC; k++) srcs[32*k +: 32] = base + 32'(k);
    endtask

    task automatic trig(input logic [1:0] sd, input logic [15:0] m,
                        input logic [31:0] s, input logic [31:0] o);
        @(posedge a_clk); #1;
        store_data = sd; src_mask = m; section = s; options = o;
        trig_cyc = cyc;
        @(posedge a_clk); #1;
        store_data = 2'd0;
    endtask

    // Waits (bounded) for the expected words, then compares count, latency and contents.
    task automatic check_stream(input string nm, input int lat_cyc);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 300) begin
            @(posedge a_clk); t++;
        end
        repeat (12) @(posedge a_clk);
        chk({nm, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
        if (lat_cyc >= 0 && got_cyc.size() > 0)
            chk({nm, " latency"}, 64'(got_cyc[0]), 64'(lat_cyc));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                chk($sformatf("%s w%0d", nm, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt[0] = mk(2'd1, 16'h8000, 32'h0, 32'h0, 1, L | 33'd16, '0, '0, '0, '0, '0);
        vt[1] = mk(2'd1, 16'h8000, 32'h0, 32'h0, 1, L | 33'd16, '0, '0, '0, '0, '0);
        vt[2] = mk(2'd2, 16'h0005, 32'hA5A5_0001, 32'h0000_00F0, 6,
                   33'h0_FEED_0005, 33'h0_A5A5_0001, 33'h0_0000_00F0, 33'd2, 33'd1, L | 33'd3);
        vt[3] = mk(2'd1, 16'h0000, 32'h0, 32'h0, 0, '0, '0, '0, '0, '0, '0);
        vt[4] = mk(2'd1, 16'h0012, 32'h0, 32'h0, 2, 33'd2, L | 33'd5, '0, '0, '0, '0);
        vt[5] = mk(2'd2, 16'h8001, 32'hDEAD_BEEF, 32'h1234_5678, 6,
                   33'h0_FEED_8001, 33'h0_DEAD_BEEF, 33'h0_1234_5678, 33'd4, 33'd1, L | 33'd16);
        vt[6] = mk(2'd3, 16'hFFFF, 32'h0, 32'h0, 0, '0, '0, '0, '0, '0, '0);

        // Reset state
        repeat (3) @(posedge a_clk); #1;
        chk("rst tvalid", 64'(M_AXIS_tvalid), 64'd0);
        chk("rst tlast", 64'(M_AXIS_tlast), 64'd0);
        chk("rst tdata", 64'(M_AXIS_tdata), 64'd0);
        chk("rst overrun", 64'(overrun_count), 64'd0);
        chk("rst level", 64'(fifo_level), 64'd0);
        a_resetn = 1'b1;
        repeat (2) @(posedge a_clk);

        // Single-trigger vectors, srcs[k] = k+1
        for (int i = 0; i < 7; i++) begin
            set_srcs(32'd1);
            for (int j = 0; j < vt[i].n; j++) exp_q.push_back(vt[i].w[j]);
            trig(vt[i].sd, vt[i].mask, vt[i].sec, vt[i].opt);
            check_stream($sformatf("vec%0d", i), trig_cyc + 3);
        end
        chk("overrun after vectors", 64'(overrun_count), 64'd0);

        // Header trigger + simultaneous finished edge, then a dropped trigger next cycle
        @(posedge a_clk); #1;
        store_data = 2'd2; src_mask = 16'h0005; section = 32'h33; options = 32'h44;
        gvp_finished = 1'b1; trig_cyc = cyc;
        @(posedge a_clk); #1;
        store_data = 2'd1;
        @(posedge a_clk); #1;
        store_data = 2'd0;
        exp_q.push_back(33'h0_FEED_0005); exp_q.push_back(33'h33); exp_q.push_back(33'h44);
        exp_q.push_back(33'd5); exp_q.push_back(33'd1); exp_q.push_back(L | 33'd3);
        exp_q.push_back(L | 33'h0_E0F0_0001);
        check_stream("overrun_end", trig_cyc + 3);
        chk("overrun one", 64'(overrun_count), 64'd1);
        gvp_finished = 1'b0;

        // Backpressure: fill the FIFO, count overruns, drain without loss
        M_AXIS_tready = 1'b0;
        set_srcs(32'hA000);
        trig(2'd1, 16'hFFFF, 32'h0, 32'h0);
        repeat (25) @(posedge a_clk); #1;
        chk("bp level A", 64'(fifo_level), 64'd15);
        chk("bp tvalid", 64'(M_AXIS_tvalid), 64'd1);
        chk("bp tdata A", 64'(M_AXIS_tdata), 64'h0000_A000);
        set_srcs(32'hB000);
        trig(2'd1, 16'hFFFF, 32'h0, 32'h0);
        repeat (10) @(posedge a_clk); #1;
        chk("bp level full", 64'(fifo_level), 64'd16);
        chk("bp tdata held", 64'(M_AXIS_tdata), 64'h0000_A000);
        chk("bp tlast held", 64'(M_AXIS_tlast), 64'd0);
        trig(2'd1, 16'hFFFF, 32'h0, 32'h0);
        repeat (3) @(posedge a_clk);
        trig(2'd2, 16'hFFFF, 32'h0, 32'h0);
        repeat (3) @(posedge a_clk); #1;
        chk("bp overrun", 64'(overrun_count), 64'd3);
        chk("bp no transfer", 64'(got_q.size()), 64'd0);
        set_srcs(32'hC000);
        for (int k = 0; k < 16; k++) exp_q.push_back(((k == 15) ? L : 33'd0) | 33'(32'hA000 + k));
        for (int k = 0; k < 16; k++) exp_q.push_back(((k == 15) ? L : 33'd0) | 33'(32'hB000 + k));
        M_AXIS_tready = 1'b1;
        check_stream("bp drain", -1);
        chk("bp level empty", 64'(fifo_level), 64'd0);

        // Reset in the middle of a data packet
        M_AXIS_tready = 1'b0;
        set_srcs(32'd1);
        trig(2'd1, 16'hFFFF, 32'h0, 32'h0);
        repeat (6) @(posedge a_clk); #1;
        a_resetn = 1'b0;
        #1;
        chk("midrst tvalid", 64'(M_AXIS_tvalid), 64'd0);
        chk("midrst level", 64'(fifo_level), 64'd0);
        chk("midrst overrun", 64'(overrun_count), 64'd0);
        repeat (2) @(posedge a_clk); #1;
        a_resetn = 1'b1;
        got_q.delete(); got_cyc.delete();
        M_AXIS_tready = 1'b1;
        exp_q.push_back(33'h0_FEED_0005); exp_q.push_back(33'h55); exp_q.push_back(33'h66);
        exp_q.push_back(33'd0); exp_q.push_back(33'd1); exp_q.push_back(L | 33'd3);
        trig(2'd2, 16'h0005, 32'h55, 32'h66);
        check_stream("after reset", trig_cyc + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
